// File: rtl/dot_prod_pkg.sv
// dot_prod_pkg: shared constants, loader state encoding and lane slicing for the weight path
package dot_prod_pkg;
  localparam int DEF_NROW = 16;
  localparam int DEF_NCOL = 16;
  localparam int DEF_BITWIDTH = 18;
  localparam int DEF_ADDR_BITWIDTH = 4;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } ld_state_e;
  // Row r of a column vector sits at bits [r*bw +: bw]; the weight RAM uses the same slicing.
  function automatic int lane_lo(input int r, input int bw);
    return r * bw;
  endfunction
endpackage

// File: rtl/weight_col_buffer.sv
// weight_col_buffer: NROW-lane column register written one lane per cycle, flattened output
//   clk, reset : clock, synchronous active-high reset
//   we_i       : write lane idx_i with data_i
//   col_o      : all lanes, lane r at bits [r*BITWIDTH +: BITWIDTH]
module weight_col_buffer import dot_prod_pkg::*; #(
  parameter int NROW = DEF_NROW,
  parameter int BITWIDTH = DEF_BITWIDTH,
  parameter int IW = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we_i,
  input  logic [IW-1:0]            idx_i,
  input  logic [BITWIDTH-1:0]      data_i,
  output logic [NROW*BITWIDTH-1:0] col_o
);
  logic [BITWIDTH-1:0] lane_q [NROW];
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NROW; i++) lane_q[i] <= '0;
    end else if (we_i) begin
      lane_q[idx_i] <= data_i;
    end
  end
  for (genvar r = 0; r < NROW; r++) begin : g_lane
    assign col_o[lane_lo(r, BITWIDTH) +: BITWIDTH] = lane_q[r];
  end
endmodule

// File: rtl/weight_loader.sv
// weight_loader: packs NROW streamed words into a column and writes NCOL columns to the weight RAM
//   start              : begin a full load (only honoured in IDLE)
//   in_data/valid/ready: word stream, column-major order
//   wr_en/addr/data    : one-cycle column write toward the RAM
//   busy, done         : activity flag, end-of-load pulse
module weight_loader import dot_prod_pkg::*; #(
  parameter int NROW = DEF_NROW,
  parameter int NCOL = DEF_NCOL,
  parameter int BITWIDTH = DEF_BITWIDTH,
  parameter int ADDR_BITWIDTH = DEF_ADDR_BITWIDTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [BITWIDTH-1:0]      in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic                     wr_en,
  output logic [ADDR_BITWIDTH-1:0] wr_addr,
  output logic [NROW*BITWIDTH-1:0] wr_data,
  output logic                     busy,
  output logic                     done
);
  localparam int RW = NROW > 1 ? $clog2(NROW) : 1;
  localparam logic [RW-1:0] ROW_LAST = RW'(NROW - 1);
  localparam logic [ADDR_BITWIDTH-1:0] COL_LAST = ADDR_BITWIDTH'(NCOL - 1);
  ld_state_e state_q, state_d;
  logic [RW-1:0] row_q, row_d;
  logic [ADDR_BITWIDTH-1:0] col_q, col_d;
  logic [NROW*BITWIDTH-1:0] buf_col, wr_data_q;
  logic hs;
  assign hs = in_valid && state_q == ST_LOAD;
  always_comb begin
    state_d = state_q;
    row_d = row_q;
    col_d = col_q;
    unique case (state_q)
      ST_IDLE: if (start) begin
        state_d = ST_LOAD;
        row_d = '0;
        col_d = '0;
      end
      ST_LOAD: if (in_valid) begin
        state_d = row_q == ROW_LAST ? ST_WRITE : ST_LOAD;
        row_d = row_q == ROW_LAST ? '0 : row_q + 1'b1;
      end
      ST_WRITE: begin
        state_d = col_q == COL_LAST ? ST_DONE : ST_LOAD;
        col_d = col_q == COL_LAST ? col_q : col_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      row_q <= '0;
      col_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q <= state_d;
      row_q <= row_d;
      col_q <= col_d;
      if (state_q == ST_WRITE) wr_data_q <= buf_col;
    end
  end
  weight_col_buffer #(.NROW(NROW), .BITWIDTH(BITWIDTH), .IW(RW)) u_buf (
    .clk    (clk),
    .reset  (reset),
    .we_i   (hs),
    .idx_i  (row_q),
    .data_i (in_data),
    .col_o  (buf_col)
  );
  assign in_ready = state_q == ST_LOAD;
  assign wr_en = state_q == ST_WRITE;
  assign wr_addr = col_q;
  // The buffer is refilled for the next column right after a write, so a shadow copy keeps wr_data stable.
  assign wr_data = wr_en ? buf_col : wr_data_q;
  assign busy = state_q != ST_IDLE;
  assign done = state_q == ST_DONE;
endmodule

// File: tb/tb_weight_loader.sv
// tb_weight_loader: directed and randomized load sequences checked against a word-list model
module tb_weight_loader;
  localparam int NR = 4;
  localparam int NC = 2;
  localparam int BW = 18;
  localparam int AW = 4;
  logic clk = 1'b0;
  logic reset, start, in_valid, in_ready, wr_en, busy, done;
  logic [BW-1:0] in_data;
  logic [AW-1:0] wr_addr;
  logic [NR*BW-1:0] wr_data;
  logic [BW-1:0] w [NR*NC];
  logic [NR*BW-1:0] last_wd, first_wd_g;
  int nerr = 0;
  int nchk = 0;
  always #5 clk = ~clk;
  weight_loader #(.NROW(NR), .NCOL(NC), .BITWIDTH(BW), .ADDR_BITWIDTH(AW)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy),
    .done     (done)
  );
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [NR*BW-1:0] pack(input int c);
    logic [NR*BW-1:0] v;
    for (int r = 0; r < NR; r++) v[r*BW +: BW] = w[c*NR + r];
    return v;
  endfunction
  task automatic gen_words(input int mode);
    for (int i = 0; i < NR*NC; i++)
      w[i] = mode == 0 ? BW'(i + 1) : BW'($urandom);
    if (mode == 2) begin
      w[0] = 18'h3FFFF;
      w[NR-1] = 18'h20000;
      w[NR] = 18'h20000;
      w[2*NR-1] = 18'h3FFFF;
    end
  endtask
  task automatic idle_chk(input string t);
    chk({t, "_in_ready"}, in_ready, 1'b0);
    chk({t, "_wr_en"}, wr_en, 1'b0);
    chk({t, "_wr_addr"}, wr_addr, 0);
    chk({t, "_wr_data"}, wr_data, 0);
    chk({t, "_busy"}, busy, 1'b0);
    chk({t, "_done"}, done, 1'b0);
  endtask
  task automatic run_load(input int gap_pct, input int gap_at, input bit noisy, input int exp_wr1, input int exp_done_cyc);
    int k = 0, wc = 0, cyc = 1, top_hits = 0, wr1 = -1, done_cyc = -1;
    bit ewr = 1'b0, edn = 1'b0, nwr, v, rdy;
    start = 1'b1;
    step();
    start = 1'b0;
    while (cyc < 400) begin
      rdy = !ewr && !edn;
      chk("in_ready", in_ready, rdy);
      chk("wr_en", wr_en, ewr);
      chk("done", done, edn);
      chk("busy", busy, 1'b1);
      chk("wr_data", wr_data, ewr ? pack(wc) : last_wd);
      if (ewr) begin
        chk("wr_addr", wr_addr, wc);
        if (wc == 0) begin
          wr1 = cyc;
          first_wd_g = wr_data;
        end
        if (wr_addr == AW'(NC - 1)) top_hits++;
        last_wd = pack(wc);
      end
      if (edn) begin
        done_cyc = cyc;
        start = 1'b0;
        in_valid = 1'b0;
        step();
        chk("post_busy", busy, 1'b0);
        chk("post_in_ready", in_ready, 1'b0);
        chk("post_done", done, 1'b0);
        chk("post_wr_en", wr_en, 1'b0);
        break;
      end
      v = (k < NR*NC) && !(cyc >= gap_at && cyc < gap_at + 3) && ($urandom_range(99) >= gap_pct);
      in_valid = v;
      in_data = v ? w[k] : BW'($urandom);
      start = noisy ? 1'($urandom_range(1)) : 1'b0;
      nwr = v && rdy && ((k + 1) % NR == 0);
      if (v && rdy) k++;
      if (ewr) wc++;
      edn = ewr && wc == NC;
      ewr = nwr;
      step();
      cyc++;
    end
    in_valid = 1'b0;
    start = 1'b0;
    chk("completed", done_cyc != -1, 1'b1);
    chk("writes", wc, NC);
    chk("last_addr_once", top_hits, 1);
    if (exp_wr1 >= 0) chk("first_wr_cycle", wr1, exp_wr1);
    if (exp_done_cyc >= 0) chk("done_cycle", done_cyc, exp_done_cyc);
  endtask
  initial begin
    int k, guard;
    bit rdy;
    reset = 1'b1;
    start = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    last_wd = '0;
    first_wd_g = '0;
    step();
    step();
    idle_chk("reset");
    reset = 1'b0;
    step();
    idle_chk("idle");
    gen_words(0);
    run_load(0, -1000, 1'b0, 5, 11);
    gen_words(0);
    run_load(0, 2, 1'b0, 8, 14);
    gen_words(0);
    run_load(0, -1000, 1'b1, 5, 11);
    gen_words(1);
    start = 1'b1;
    step();
    start = 1'b0;
    k = 0;
    guard = 0;
    while (k < 6 && guard < 50) begin
      rdy = in_ready;
      in_valid = 1'b1;
      in_data = w[k];
      step();
      if (rdy) k++;
      guard++;
    end
    chk("rst_reached", k, 6);
    reset = 1'b1;
    in_valid = 1'b0;
    step();
    reset = 1'b0;
    last_wd = '0;
    idle_chk("midrst");
    repeat (3) begin
      step();
      chk("idle_wr_en", wr_en, 1'b0);
      chk("idle_busy", busy, 1'b0);
    end
    gen_words(1);
    run_load(0, -1000, 1'b0, 5, 11);
    gen_words(2);
    run_load(0, -1000, 1'b0, 5, 11);
    chk("lane0_max", first_wd_g[BW-1:0], 18'h3FFFF);
    chk("laneN_min", first_wd_g[NR*BW-1 -: BW], 18'h20000);
    repeat (3) begin
      gen_words(1);
      run_load(30, -1000, 1'b1, -1, -1);
    end
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/weight_loader.md
# weight_loader

Stream-to-column write engine that fills the weight memory consumed by the dot-product datapath. It accepts weights one word at a time over a valid/ready stream, packs NROW consecutive words into one column vector, and writes that vector to column address `wr_addr` in a single cycle. It is the write-side counterpart of the column-addressed weight RAM. The `wr_data` lane packing is identical to that RAM's row-vector output, so a written column reads back unchanged.

## Interface
- NROW, 16, rows per column: words per write.
- NCOL, 16, columns per load: writes per load.
- BITWIDTH, 18, width of one weight word.
- ADDR_BITWIDTH, 4, column address width; must be ≥ clog2(NCOL).

- clk  in  1  single clock, rising-edge.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle request to begin a full load; ignored unless IDLE.
- in_data  in  BITWIDTH  weight word.
- in_valid  in  1  in_data valid.
- in_ready  out  1  loader accepts a word this cycle.
- wr_en  out  1  one-cycle column write strobe.
- wr_addr  out  ADDR_BITWIDTH  column address being written.
- wr_data  out  NROW*BITWIDTH  column vector; row r in bits [r*BITWIDTH +: BITWIDTH].
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last column is written.

## Operation
- Reset values:
  - State: IDLE.
  - Outputs: in_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0.
  - Counters: row_cnt=0, col_cnt=0.
- FSM states: IDLE, LOAD, WRITE, DONE.
- IDLE:
  - start=1 → LOAD; row_cnt and col_cnt cleared.
- LOAD:
  - in_ready=1.
  - On each handshake (in_valid & in_ready), in_data is stored into lane row_cnt of the column buffer and row_cnt increments.
  - The handshake with row_cnt=NROW-1 → WRITE; row_cnt wraps to 0.
  - in_valid low: state holds, nothing is captured.
- WRITE:
  - in_ready=0; wr_en=1; wr_addr=col_cnt; wr_data=column buffer.
  - If col_cnt=NCOL-1 → DONE. Otherwise col_cnt increments and the FSM returns to LOAD.
- DONE:
  - done=1, in_ready=0 → IDLE.
- Word order is column-major: column 0 rows 0..NROW-1, then column 1, and so on.
- Words are stored unmodified; there is no sign handling or arithmetic on data.
- wr_data holds its last written value outside wr_en cycles. The column buffer is not cleared between columns; every lane is overwritten before each write.
- start while busy: ignored, with no effect on counters or state.
- reset mid-load: immediate return to IDLE.
  - No write is issued for the partial column.
  - The partial column is discarded.
  - A later start restarts at column 0.
- in_valid while not in_ready: the word is not consumed; the source must hold it.

## Timing
- in_ready is a registered state decode and does not depend combinationally on in_valid.
- Latency: the handshake of row NROW-1 at edge t gives wr_en=1 in cycle t+1.
- Throughput: NROW+1 cycles per column with in_valid held high.
- Full load with continuous valid:
  - start is sampled at edge 0.
  - in_ready is first high in cycle 1.
  - The final wr_en occurs NCOL*(NROW+1) cycles after start.
  - done follows in the next cycle.
  - busy falls the cycle after done.
- The RAM side samples wr_en/wr_addr/wr_data on the rising edge of clk. The read port of the weight RAM stays on the falling edge, so a column written in cycle t is readable from the next falling edge.

## Structure
- Shared package (dot_prod_pkg) holds:
  - Default constants: NROW, NCOL, BITWIDTH, ADDR_BITWIDTH.
  - The loader state enum.
  - A lane-slice helper (r*BITWIDTH base) shared with the weight RAM.
- One natural sub-module: weight_col_buffer.
  - NROW×BITWIDTH lane register with indexed write enable.
  - Flattened output.
- FSM and counters live in weight_loader.

## Test plan
- Reset, then idle: all outputs 0.
  - Pulse start with NROW=4, NCOL=2; stream words 1..8 with continuous valid.
  - Expected: wr_en in cycles 5 and 10.
  - Write 1: addr 0, lanes {1,2,3,4} with lane 0 = LSB slice.
  - Write 2: addr 1, lanes {5,6,7,8}.
  - done pulses in cycle 11.
- Backpressure and gaps: drop in_valid for 3 cycles mid-column.
  - Expected: no words captured during the gaps.
  - Write contents unchanged; the write is delayed by exactly 3 cycles.
- start asserted during LOAD and during WRITE.
  - Expected: counters unaffected; the sequence completes exactly as in the first scenario.
- reset asserted after 2 words of column 1.
  - Expected: the next cycle is IDLE, no wr_en, outputs back to reset values.
  - A new start with 8 words writes addr 0 first.
- Boundary values: words 0x3FFFF and 0x20000 in lanes 0 and NROW-1.
  - Expected: exact bit positions in wr_data with no sign extension.
  - wr_addr reaches NCOL-1 exactly once per load.
